// File: rtl/fns_pkg.sv
// Shared helpers for the Fibonacci-numeral-system (FNS) TSV coder.
package fns_pkg;

  // Number of code lines resolved by each pipeline stage; the last stage
  // resolves whatever is left over.
  function automatic int fns_bps(input int n, input int stages);
    return (n + stages - 1) / stages;
  endfunction

  // Weight of code line idx in the default Fibonacci table (1,1,2,3,5,...),
  // truncated to dw bits so it fits one weight field.
  function automatic longint unsigned FNS_DEF_W(input int idx, input int dw);
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
    a = 64'd1;
    b = 64'd1;
    for (int k = 0; k < idx; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    if (dw < 64) begin
      a = a & ((64'd1 << dw) - 64'd1);
    end
    return a;
  endfunction

endpackage

// File: rtl/fns_coder_pipe_if.sv
// Bus bundle of the FNS coder: configuration port, input stream and output stream.
interface fns_coder_pipe_if #(
  parameter int DW = 8,
  parameter int N  = 9
);
  logic          cfg_we;
  logic [N*DW-1:0] cfg_w;
  logic [N-1:0]  cfg_mask;
  logic          cfg_busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] datain;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  codeout;
  logic          ovf;

  // Data source / consumer side
  modport master (
    output cfg_we, cfg_w, cfg_mask, in_valid, datain, out_ready,
    input  cfg_busy, in_ready, out_valid, codeout, ovf
  );

  // Coder side
  modport slave (
    input  cfg_we, cfg_w, cfg_mask, in_valid, datain, out_ready,
    output cfg_busy, in_ready, out_valid, codeout, ovf
  );
endinterface

// File: rtl/fns_coder_stage.sv
// One pipeline stage of the FNS coder: greedy decomposition over lines HI..LO
// of the residual handed over by the previous stage, plus the stage register.
// A stage with HI < LO resolves no lines and only forwards its word.
module fns_coder_stage #(
  parameter int DW = 8,
  parameter int N  = 9,
  parameter int LO = 0,
  parameter int HI = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            adv_i,
  input  logic            valid_i,
  input  logic [DW-1:0]   r_i,
  input  logic [N-1:0]    code_i,
  input  logic [N*DW-1:0] w_i,
  input  logic [N-1:0]    mask_i,
  output logic            valid_o,
  output logic [DW-1:0]   r_o,
  output logic [N-1:0]    code_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] r_q, r_d;
  logic [N-1:0]  code_q, code_d;
  logic [DW-1:0] rRes;
  logic [N-1:0]  codeRes;
  logic          take;

  // Greedy MSB-first step over this stage's lines; masked lines stay 0 and keep the residual
  always_comb begin
    rRes    = r_i;
    codeRes = code_i;
    take    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i <= HI && i >= LO) begin
        take       = mask_i[i] && (rRes >= w_i[i*DW +: DW]);
        codeRes[i] = take;
        if (take) begin
          rRes = rRes - w_i[i*DW +: DW];
        end
      end
    end
  end

  // Load a new word when the stage advances, otherwise hold; data only moves with a valid word
  always_comb begin
    valid_d = valid_q;
    r_d     = r_q;
    code_d  = code_q;
    if (adv_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        r_d    = rRes;
        code_d = codeRes;
      end
    end
  end

  // Stage register with synchronous flush
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      r_q     <= '0;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      r_q     <= r_d;
      code_q  <= code_d;
    end
  end

  assign valid_o = valid_q;
  assign r_o     = r_q;
  assign code_o  = code_q;

endmodule

// File: rtl/fns_coder_pipe.sv
// Pipelined FNS crosstalk-avoidance encoder for a TSV bundle with a run-time
// weight/mask table and valid/ready flow control on both sides.
module fns_coder_pipe
  import fns_pkg::*;
#(
  parameter int DW     = 8,
  parameter int N      = 9,
  parameter int STAGES = 3
) (
  input logic             clock,
  input logic             reset,
  fns_coder_pipe_if.slave bus
);

  localparam int BPS = fns_bps(N, STAGES);

  function automatic logic [N*DW-1:0] defTable();
    logic [N*DW-1:0] t;
    longint unsigned w;
    t = '0;
    for (int i = 0; i < N; i++) begin
      w = FNS_DEF_W(i, DW);
      t[i*DW +: DW] = w[DW-1:0];
    end
    return t;
  endfunction

  localparam logic [N*DW-1:0] DEF_W = defTable();

  logic [N*DW-1:0] wTab_q, wTab_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [STAGES:0] adv;
  logic [STAGES-1:0] stValid;
  logic [DW-1:0]   stR [STAGES];
  logic [N-1:0]    stCode [STAGES];
  logic            inHandshake;
  logic            cfgApply;

  // Backpressure chain: a stage may move if it is empty or the stage after it moves
  always_comb begin
    adv = '0;
    adv[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !stValid[k] || adv[k + 1];
    end
  end

  assign bus.in_ready = adv[0] && !reset;
  assign inHandshake  = bus.in_valid && bus.in_ready;

  // The table only changes with the pipe empty and nothing entering, so no word sees two tables
  assign cfgApply     = bus.cfg_we && !(|stValid) && !inHandshake && !reset;
  assign bus.cfg_busy = bus.cfg_we && !reset && !cfgApply;

  // Next weight table and mask
  always_comb begin
    wTab_d = wTab_q;
    mask_d = mask_q;
    if (cfgApply) begin
      wTab_d = bus.cfg_w;
      mask_d = bus.cfg_mask;
    end
  end

  // Table register, back to the Fibonacci table with all lines usable on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wTab_q <= DEF_W;
      mask_q <= '1;
    end else begin
      wTab_q <= wTab_d;
      mask_q <= mask_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    localparam int HI = N - 1 - k * BPS;
    localparam int LO = (k == STAGES - 1) ? 0 : N - (k + 1) * BPS;

    logic          upValid;
    logic [DW-1:0] upR;
    logic [N-1:0]  upCode;

    if (k == 0) begin : gFirst
      assign upValid = bus.in_valid;
      assign upR     = bus.datain;
      assign upCode  = '0;
    end else begin : gNext
      assign upValid = stValid[k - 1];
      assign upR     = stR[k - 1];
      assign upCode  = stCode[k - 1];
    end

    fns_coder_stage #(
      .DW(DW),
      .N (N),
      .LO(LO),
      .HI(HI)
    ) uStage (
      .clock  (clock),
      .reset  (reset),
      .adv_i  (adv[k]),
      .valid_i(upValid),
      .r_i    (upR),
      .code_i (upCode),
      .w_i    (wTab_q),
      .mask_i (mask_q),
      .valid_o(stValid[k]),
      .r_o    (stR[k]),
      .code_o (stCode[k])
    );
  end

  assign bus.out_valid = stValid[STAGES - 1];
  assign bus.codeout   = stCode[STAGES - 1];
  assign bus.ovf       = |stR[STAGES - 1];

endmodule

// File: tb/tb_fns_coder_pipe.sv
// Self-checking bench for fns_coder_pipe: directed corner cases, a stalled
// stream and a randomized phase, all against an integer greedy model.
module tb_fns_coder_pipe;

  localparam int DW     = 8;
  localparam int N      = 9;
  localparam int STAGES = 3;
  localparam logic [N*DW-1:0] FIB_TABLE =
    {8'd34, 8'd21, 8'd13, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1, 8'd1};

  logic clock = 1'b0;
  logic reset = 1'b1;

  fns_coder_pipe_if #(.DW(DW), .N(N)) bus ();

  fns_coder_pipe #(
    .DW    (DW),
    .N     (N),
    .STAGES(STAGES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int          modelW [N];
  logic [N-1:0] modelMask;
  logic [9:0]  expQ [$];
  logic        holdPending = 1'b0;
  logic [N-1:0] heldCode;
  logic        heldOvf;
  logic        lastInHs;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic modelReset();
    logic [N*DW-1:0] t;
    t = FIB_TABLE;
    for (int i = 0; i < N; i++) modelW[i] = int'(t[i*DW +: DW]);
    modelMask = '1;
  endtask

  function automatic logic [9:0] refEncode(input int value);
    int r;
    logic [N-1:0] c;
    r = value;
    c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (modelMask[i] && r >= modelW[i]) begin
        c[i] = 1'b1;
        r = r - modelW[i];
      end
    end
    return {r != 0, c};
  endfunction

  task automatic applyStimulus(input logic valid, input int data, input logic outReady);
    bus.in_valid  = valid;
    bus.datain    = DW'(data);
    bus.out_ready = outReady;
  endtask

  task automatic applyConfig(input logic [N*DW-1:0] w, input logic [N-1:0] mask);
    bus.cfg_we   = 1'b1;
    bus.cfg_w    = w;
    bus.cfg_mask = mask;
  endtask

  task automatic clearConfig();
    bus.cfg_we = 1'b0;
  endtask

  // One clock: check flow control, config, held outputs and output words, then advance
  task automatic cycle();
    logic inHs;
    logic outHs;
    logic expApply;
    logic [9:0] expWord;
    #1;
    inHs  = bus.in_valid && bus.in_ready;
    outHs = bus.out_valid && bus.out_ready;
    lastInHs = inHs;
    if (!reset) begin
      checkOutput("in_ready", bus.in_ready, (expQ.size() < STAGES) || bus.out_ready);
      expApply = bus.cfg_we && (expQ.size() == 0) &&
                 !(bus.in_valid && ((expQ.size() < STAGES) || bus.out_ready));
      checkOutput("cfg_busy", bus.cfg_busy, bus.cfg_we && !expApply);
      if (holdPending) begin
        checkOutput("hold_valid", bus.out_valid, 1);
        checkOutput("hold_code", bus.codeout, heldCode);
        checkOutput("hold_ovf", bus.ovf, heldOvf);
      end
      if (outHs) begin
        checkOutput("out_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          expWord = expQ.pop_front();
          checkOutput("out_code", bus.codeout, expWord[8:0]);
          checkOutput("out_ovf", bus.ovf, expWord[9]);
        end
      end
      holdPending = bus.out_valid && !bus.out_ready;
      heldCode    = bus.codeout;
      heldOvf     = bus.ovf;
      if (inHs) expQ.push_back(refEncode(int'(bus.datain)));
      if (expApply) begin
        for (int i = 0; i < N; i++) modelW[i] = int'(bus.cfg_w[i*DW +: DW]);
        modelMask = bus.cfg_mask;
      end
    end else begin
      holdPending = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    applyStimulus(1'b0, 0, 1'b1);
    while (expQ.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    checkOutput("drain_empty", expQ.size(), 0);
  endtask

  task automatic sendAndExpect(input string tag, input int value,
                               input logic [N-1:0] expCode, input logic expOvf);
    int n;
    applyStimulus(1'b1, value, 1'b1);
    cycle();
    applyStimulus(1'b0, 0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      cycle();
      n++;
    end
    checkOutput({tag, "_latency"}, n, STAGES - 1);
    checkOutput({tag, "_code"}, bus.codeout, expCode);
    checkOutput({tag, "_ovf"}, bus.ovf, expOvf);
    cycle();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nextVal;
    logic [N*DW-1:0] tbl;

    bus.cfg_we    = 1'b0;
    bus.cfg_w     = FIB_TABLE;
    bus.cfg_mask  = '1;
    bus.in_valid  = 1'b1;
    bus.datain    = '0;
    bus.out_ready = 1'b1;
    modelReset();

    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_codeout", bus.codeout, 0);
    checkOutput("rst_ovf", bus.ovf, 0);
    checkOutput("rst_cfg_busy", bus.cfg_busy, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    applyStimulus(1'b0, 0, 1'b1);
    #1;
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

    $display("[TB] directed encodes");
    sendAndExpect("fib20", 20, 9'h054, 1'b0);
    applyConfig(FIB_TABLE, 9'h1BF);
    #1;
    checkOutput("cfg_idle_busy", bus.cfg_busy, 0);
    cycle();
    clearConfig();
    sendAndExpect("mask20", 20, 9'h03F, 1'b0);
    applyConfig(FIB_TABLE, 9'h1FF);
    cycle();
    clearConfig();
    sendAndExpect("max88", 88, 9'h1FF, 1'b0);
    sendAndExpect("ovf89", 89, 9'h1FF, 1'b1);
    applyConfig(FIB_TABLE, 9'h000);
    cycle();
    clearConfig();
    sendAndExpect("mask0", 5, 9'h000, 1'b1);
    applyConfig(FIB_TABLE, 9'h1FF);
    cycle();
    clearConfig();

    $display("[TB] stalled stream 0..88");
    nextVal = 0;
    for (int cyc = 0; cyc < 300 && nextVal <= 88; cyc++) begin
      applyStimulus(1'b1, nextVal, !(cyc >= 4 && cyc <= 10));
      if (cyc == 7) begin
        #1;
        checkOutput("stall_in_ready_low", bus.in_ready, 0);
      end
      if (cyc == 11) begin
        #1;
        checkOutput("resume_in_ready_high", bus.in_ready, 1);
      end
      cycle();
      if (lastInHs) nextVal++;
    end
    checkOutput("stream_all_sent", nextVal, 89);
    drain();

    $display("[TB] config while busy");
    applyStimulus(1'b1, 40, 1'b1);
    cycle();
    applyStimulus(1'b1, 77, 1'b1);
    cycle();
    applyStimulus(1'b0, 0, 1'b1);
    applyConfig(FIB_TABLE, 9'h0FF);
    #1;
    checkOutput("cfg_busy_inflight", bus.cfg_busy, 1);
    cycle();
    clearConfig();
    drain();
    applyConfig(FIB_TABLE, 9'h0FF);
    #1;
    checkOutput("cfg_retry_busy", bus.cfg_busy, 0);
    cycle();
    clearConfig();
    sendAndExpect("newmask40", 40, 9'h0D2, 1'b0);

    $display("[TB] reset with words in flight");
    applyStimulus(1'b1, 30, 1'b0);
    cycle();
    applyStimulus(1'b1, 31, 1'b0);
    cycle();
    applyStimulus(1'b1, 32, 1'b0);
    cycle();
    applyStimulus(1'b0, 0, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    expQ.delete();
    modelReset();
    holdPending = 1'b0;
    checkOutput("flush_out_valid", bus.out_valid, 0);
    checkOutput("flush_codeout", bus.codeout, 0);
    applyStimulus(1'b0, 0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      cycle();
      checkOutput("no_stale_word", bus.out_valid, 0);
    end
    sendAndExpect("reset_table40", 40, 9'h112, 1'b0);

    $display("[TB] randomized traffic");
    for (int cyc = 0; cyc < 600; cyc++) begin
      applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                    $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        tbl = FIB_TABLE;
        if ($urandom_range(0, 1) == 1) begin
          for (int i = 0; i < N; i++) tbl[i*DW +: DW] = DW'($urandom_range(1, 255));
        end
        applyConfig(tbl, N'($urandom_range(0, 511)));
      end else begin
        clearConfig();
      end
      cycle();
    end
    clearConfig();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
